seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
- Time-multiplexes one shared BCD-to-seven-segment decoder across the board's DIGITS common-anode digits.
- Feeds the decoder one nibble at a time and drives the active-low anodes and decimal point.
- Inserts dead time between digits to suppress ghosting.
- Takes display updates over a valid/ready handshake and applies them only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
- DIGITS, 4: number of multiplexed digits; frame length is DIGITS slots.
- PRESCALE, 50000: clk cycles per digit slot; must be > BLANK_CYCLES.
- BLANK_CYCLES, 500: cycles at the start of each slot with all anodes off; must be ≥ 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- enable  in  1  scan enable; low forces the display dark.
- load_valid  in  1  new display word offered.
- load_ready  out  1  pending buffer empty; a word is accepted when load_valid & load_ready.
- load_value  in  4*DIGITS  BCD nibbles; digit 0 is nibble [3:0].
- load_dp  in  DIGITS  decimal-point request per digit, 1 = lit.
- digit_code  out  4  nibble to the shared decoder inputs d3..d0.
- an_n  out  DIGITS  anode enables, active low.
- dp_n  out  1  decimal point, active low.
- upd_pulse  out  1  one-cycle pulse when the pending word becomes active.
- frame_pulse  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Clock, reset and sampling
  - One clock domain. Reset is synchronous and active-low: `rst_n` is sampled on the rising edge of `clk`.
- Reset values
  - an_n = all 1, dp_n = 1, digit_code = 0, load_ready = 1, upd_pulse = 0, frame_pulse = 0.
  - Active word = 0, active dp = 0, pending empty, idx = 0, slot counter = 0, state = BLANK.
- State machine (BLANK, DRIVE), with per-digit index idx and slot counter cnt of width $clog2(PRESCALE)
  - BLANK: an_n all 1 and dp_n = 1; cnt increments.
    - At cnt == BLANK_CYCLES-1, go to DRIVE.
  - DRIVE: an_n[idx] = 0 and all other anodes 1; dp_n = ~active_dp[idx]; cnt increments.
    - At cnt == PRESCALE-1: cnt <= 0, idx <= idx+1, wrapping DIGITS-1 -> 0; go to BLANK.
  - Each slot is exactly PRESCALE cycles; a frame is DIGITS*PRESCALE cycles.
- digit_code
  - Equals active_word[4*idx +: 4] in both states.
  - It settles during BLANK, so the decoder output is stable before the anode turns on.
- Invalid nibbles
  - A nibble above 9 keeps its anode off (treated as BLANK) for the whole slot.
  - digit_code still carries that nibble.
- Outputs are registered
  - an_n and dp_n change one cycle after the state or idx change that causes them.
- Frame boundary
  - The cycle in which DRIVE ends with idx == DIGITS-1.
  - frame_pulse is asserted in the following cycle.
- Update handshake
  - One-entry pending buffer.
  - On load_valid & load_ready: capture load_value and load_dp into pending; load_ready <= 0.
  - At a frame boundary with pending full: active <= pending, pending empty, upd_pulse = 1 in the next cycle, load_ready <= 1 in the same cycle.
  - A word accepted in the same cycle as a frame boundary while pending was empty is held in pending until the next frame boundary.
  - load_valid while load_ready = 0 is ignored; the source must hold it.
- enable low
  - Synchronous: next cycle state = BLANK, cnt = 0, idx = 0, an_n all 1, dp_n = 1, frame_pulse = 0.
  - The handshake still works and pending is kept.
  - The pending word is applied at the first frame boundary after enable returns high.
- Reset mid-frame
  - Restores all reset values within one cycle.
  - Any pending word is discarded.

Decomposition:
- Shared package seg_pkg holds:
  - localparams BCD_MAX = 9 and NIBBLE_W = 4;
  - the state enum {ST_BLANK, ST_DRIVE};
  - the function is_bcd(nibble).
- One natural sub-module: seg_slot_timer, which holds the cnt/idx counters, produces the end-of-blank and end-of-slot strobes, and sits under seg_scan_ctrl.
- The seven-segment decoder itself is instantiated by the parent, not inside this block.

Test Plan:
- Sim parameters: DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
- Reset then enable=1 -> an_n sequence per slot is 1111×2 then 1110×6, then 1111×2 then 1101×6, and so on; frame_pulse every 32 cycles; digit_code = 0.
- Load value=16'h4321, dp=4'b0010 mid-frame -> load_ready drops the next cycle; upd_pulse and load_ready=1 right after the frame boundary; in the next frame digit_code per slot is 1,2,3,4 and dp_n=0 only in slot 1.
- Second load while pending is full -> not accepted, load_ready stays 0; held value is accepted the cycle after upd_pulse and applied one frame later.
- Nibble 4'hA in digit 2 -> an_n[2] stays 1 for the whole slot; other digits scan normally.
- enable dropped mid-DRIVE of digit 2 -> next cycle an_n=1111, idx=0; on re-enable, scanning restarts at digit 0 with a 2-cycle blank.
- rst_n low for 1 cycle with pending full and idx=3 -> all reset values, load_ready=1, pending discarded, digit_code=0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scan controller.
// Holds the scan state encoding and the BCD validity check.
package seg_pkg;

   localparam int unsigned BCD_MAX  = 9;
   localparam int unsigned NIBBLE_W = 4;

   typedef enum logic [0:0] {
      ST_BLANK,
      ST_DRIVE
   } seg_state_e;

   function automatic logic is_bcd(input logic [NIBBLE_W-1:0] nibble);
      return (nibble <= NIBBLE_W'(BCD_MAX));
   endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot counter and digit index for the scan controller.
// Emits end-of-blank, end-of-slot and end-of-frame strobes for the current state.
module seg_slot_timer
   import seg_pkg::*;
#(
   parameter int unsigned DIGITS       = 4,
   parameter int unsigned PRESCALE     = 50000,
   parameter int unsigned BLANK_CYCLES = 500,
   parameter int unsigned IDX_W        = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_enable,
   input  seg_state_e       i_state,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_end_blank,
   output logic             o_end_slot,
   output logic             o_end_frame
);

   localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [CNT_W-1:0] r_cnt;
   logic [IDX_W-1:0] r_idx;

   assign o_end_blank = i_enable && (i_state == ST_BLANK) &&
                        (r_cnt == CNT_W'(BLANK_CYCLES - 1));
   assign o_end_slot  = i_enable && (i_state == ST_DRIVE) &&
                        (r_cnt == CNT_W'(PRESCALE - 1));
   assign o_end_frame = o_end_slot && (r_idx == IDX_W'(DIGITS - 1));
   assign o_idx       = r_idx;

   // The count runs through blank and drive, so one slot is always PRESCALE cycles.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || !i_enable) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else if (o_end_slot) begin
         r_cnt <= '0;
         r_idx <= o_end_frame ? '0 : r_idx + 1'b1;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan of DIGITS common-anode digits through one shared decoder.
// New display words are staged in a one-entry buffer and swapped in at frame boundaries.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int unsigned DIGITS       = 4,
   parameter int unsigned PRESCALE     = 50000,
   parameter int unsigned BLANK_CYCLES = 500
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_enable,
   input  logic                       i_load_valid,
   output logic                       o_load_ready,
   input  logic [NIBBLE_W*DIGITS-1:0] i_load_value,
   input  logic [DIGITS-1:0]          i_load_dp,
   output logic [NIBBLE_W-1:0]        o_digit_code,
   output logic [DIGITS-1:0]          o_an_n,
   output logic                       o_dp_n,
   output logic                       o_upd_pulse,
   output logic                       o_frame_pulse
);

   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   seg_state_e                 r_state;
   seg_state_e                 w_state_d;
   logic [IDX_W-1:0]           w_idx;
   logic                       w_end_blank;
   logic                       w_end_slot;
   logic                       w_end_frame;
   logic                       w_accept;
   logic [NIBBLE_W-1:0]        w_nibble;
   logic [DIGITS-1:0]          w_an_n_d;
   logic                       w_dp_n_d;

   logic [NIBBLE_W*DIGITS-1:0] r_act_word;
   logic [DIGITS-1:0]          r_act_dp;
   logic [NIBBLE_W*DIGITS-1:0] r_pend_word;
   logic [DIGITS-1:0]          r_pend_dp;
   logic                       r_pend_full;
   logic [DIGITS-1:0]          r_an_n;
   logic                       r_dp_n;
   logic                       r_upd_pulse;
   logic                       r_frame_pulse;

   seg_slot_timer #(
      .DIGITS       (DIGITS),
      .PRESCALE     (PRESCALE),
      .BLANK_CYCLES (BLANK_CYCLES),
      .IDX_W        (IDX_W)
   ) u_timer (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_enable    (i_enable),
      .i_state     (r_state),
      .o_idx       (w_idx),
      .o_end_blank (w_end_blank),
      .o_end_slot  (w_end_slot),
      .o_end_frame (w_end_frame)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= ST_BLANK;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      if (!i_enable) begin
         w_state_d = ST_BLANK;
      end else begin
         unique case (r_state)
            ST_BLANK: if (w_end_blank) w_state_d = ST_DRIVE;
            ST_DRIVE: if (w_end_slot)  w_state_d = ST_BLANK;
            default:  w_state_d = ST_BLANK;
         endcase
      end
   end

   // Non-BCD nibbles keep their anode dark for the whole slot.
   assign w_nibble = r_act_word[NIBBLE_W*w_idx +: NIBBLE_W];

   always_comb begin
      w_an_n_d = '1;
      w_dp_n_d = 1'b1;
      if (i_enable && (r_state == ST_DRIVE) && is_bcd(w_nibble)) begin
         w_an_n_d[w_idx] = 1'b0;
         w_dp_n_d        = ~r_act_dp[w_idx];
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_an_n        <= '1;
         r_dp_n        <= 1'b1;
         r_frame_pulse <= 1'b0;
         r_upd_pulse   <= 1'b0;
      end else begin
         r_an_n        <= w_an_n_d;
         r_dp_n        <= w_dp_n_d;
         r_frame_pulse <= w_end_frame;
         r_upd_pulse   <= w_end_frame && r_pend_full;
      end
   end

   assign w_accept = i_load_valid && !r_pend_full;

   // Pending can only be full or accepting in a given cycle, never both.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_act_word  <= '0;
         r_act_dp    <= '0;
         r_pend_word <= '0;
         r_pend_dp   <= '0;
         r_pend_full <= 1'b0;
      end else if (w_end_frame && r_pend_full) begin
         r_act_word  <= r_pend_word;
         r_act_dp    <= r_pend_dp;
         r_pend_full <= 1'b0;
      end else if (w_accept) begin
         r_pend_word <= i_load_value;
         r_pend_dp   <= i_load_dp;
         r_pend_full <= 1'b1;
      end
   end

   assign o_load_ready  = !r_pend_full;
   assign o_digit_code  = w_nibble;
   assign o_an_n        = r_an_n;
   assign o_dp_n        = r_dp_n;
   assign o_upd_pulse   = r_upd_pulse;
   assign o_frame_pulse = r_frame_pulse;

endmodule
